// File: rtl/harris_tile_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// harris_tile_sched : raster-order 4x4 tile scheduler feeding the Sobel stage
// Revision 1.0
// ----------------------------------------------------------------------------
module harris_tile_sched #(
  parameter int IMG_W    = 34,
  parameter int IMG_H    = 34,
  parameter int GRAD_LAT = 1,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          fetch_req,
  output logic [RW-1:0] fetch_row,
  output logic [CW-1:0] fetch_col,
  input  logic          fetch_ack,
  output logic          win_valid,
  output logic          tile_valid,
  output logic [RW-1:0] tile_row,
  output logic [CW-1:0] tile_col,
  input  logic          tile_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_COMPUTE = 3'd2,
    S_EMIT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [3:0]    LAT_M1    = 4'(GRAD_LAT - 1);
  localparam logic [CW-1:0] COL_LIMIT = CW'(IMG_W - 2);
  localparam logic [RW-1:0] ROW_LIMIT = RW'(IMG_H - 2);

  state_t        r_state, w_next_state;
  logic [RW-1:0] r_row, w_next_row;
  logic [CW-1:0] r_col, w_next_col;
  logic [3:0]    r_cnt, w_next_cnt;

  always_comb begin
    w_next_state = r_state;
    w_next_row   = r_row;
    w_next_col   = r_col;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_FETCH;
          w_next_row   = '0;
          w_next_col   = '0;
        end
      end
      S_FETCH: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (fetch_ack) begin
          w_next_state = S_COMPUTE;
          w_next_cnt   = '0;
        end
      end
      S_COMPUTE: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == LAT_M1) begin
          w_next_state = S_EMIT;
        end else begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end
      S_EMIT: begin
        // abort outranks a same-cycle handshake, so the tile is dropped
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (tile_ready) begin
          if ((r_col + CW'(4)) < COL_LIMIT) begin
            w_next_col   = r_col + CW'(4);
            w_next_state = S_FETCH;
          end else if ((r_row + RW'(4)) < ROW_LIMIT) begin
            w_next_col   = '0;
            w_next_row   = r_row + RW'(4);
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_DONE;
          end
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so no input reaches a port combinationally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_cnt      <= '0;
      fetch_req  <= 1'b0;
      fetch_row  <= '0;
      fetch_col  <= '0;
      win_valid  <= 1'b0;
      tile_valid <= 1'b0;
      tile_row   <= '0;
      tile_col   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_row      <= w_next_row;
      r_col      <= w_next_col;
      r_cnt      <= w_next_cnt;
      fetch_req  <= (w_next_state == S_FETCH);
      fetch_row  <= (w_next_state == S_FETCH) ? w_next_row : '0;
      fetch_col  <= (w_next_state == S_FETCH) ? w_next_col : '0;
      win_valid  <= (w_next_state == S_COMPUTE) && (r_state != S_COMPUTE);
      tile_valid <= (w_next_state == S_EMIT);
      tile_row   <= (w_next_state == S_EMIT) ? w_next_row : '0;
      tile_col   <= (w_next_state == S_EMIT) ? w_next_col : '0;
      busy       <= (w_next_state != S_IDLE);
      done       <= (w_next_state == S_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_harris_tile_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_harris_tile_sched : directed bench with a transaction-level frame model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_harris_tile_sched;

  localparam int GL_A = 1;
  localparam int GL_B = 3;
  localparam int TX   = 8;
  localparam int NT   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset = 1'b0, a_start = 1'b0, a_abort = 1'b0, a_ack = 1'b0, a_ready = 1'b0;
  logic       a_fetch_req, a_win_valid, a_tile_valid, a_busy, a_done;
  logic [5:0] a_fetch_row, a_fetch_col, a_tile_row, a_tile_col;

  logic       b_reset = 1'b0, b_start = 1'b0, b_abort = 1'b0, b_ack = 1'b0, b_ready = 1'b0;
  logic       b_fetch_req, b_win_valid, b_tile_valid, b_busy, b_done;
  logic [5:0] b_fetch_row, b_fetch_col, b_tile_row, b_tile_col;

  harris_tile_sched #(.IMG_W(34), .IMG_H(34), .GRAD_LAT(GL_A)) dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .abort(a_abort),
    .fetch_req(a_fetch_req), .fetch_row(a_fetch_row), .fetch_col(a_fetch_col),
    .fetch_ack(a_ack), .win_valid(a_win_valid), .tile_valid(a_tile_valid),
    .tile_row(a_tile_row), .tile_col(a_tile_col), .tile_ready(a_ready),
    .busy(a_busy), .done(a_done)
  );

  harris_tile_sched #(.IMG_W(34), .IMG_H(34), .GRAD_LAT(GL_B)) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .abort(b_abort),
    .fetch_req(b_fetch_req), .fetch_row(b_fetch_row), .fetch_col(b_fetch_col),
    .fetch_ack(b_ack), .win_valid(b_win_valid), .tile_valid(b_tile_valid),
    .tile_row(b_tile_row), .tile_col(b_tile_col), .tile_ready(b_ready),
    .busy(b_busy), .done(b_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model for dut_a: a tile index k walks the frame; position is k's raster coordinates.
  localparam int M_IDLE = 0, M_FETCH = 1, M_COMP = 2, M_EMIT = 3, M_DONE = 4;
  int m_mode = M_IDLE;
  int m_k    = 0;
  int m_left = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    if (!a_reset) begin
      m_mode <= M_IDLE;
      m_k    <= 0;
    end else begin
      case (m_mode)
        M_IDLE:  if (a_start) begin m_mode <= M_FETCH; m_k <= 0; end
        M_FETCH: if (a_abort) m_mode <= M_IDLE;
                 else if (a_ack) begin m_mode <= M_COMP; m_left <= GL_A; end
        M_COMP:  if (a_abort) m_mode <= M_IDLE;
                 else if (m_left == 1) m_mode <= M_EMIT;
                 else m_left <= m_left - 1;
        M_EMIT:  if (a_abort) m_mode <= M_IDLE;
                 else if (a_ready) begin
                   if (m_k == NT - 1) m_mode <= M_DONE;
                   else begin m_k <= m_k + 1; m_mode <= M_FETCH; end
                 end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    int er, ec;
    bit ef, et;
    if (chk_en) begin
      er = (m_k / TX) * 4;
      ec = (m_k % TX) * 4;
      ef = (m_mode == M_FETCH);
      et = (m_mode == M_EMIT);
      check("fetch_req",  a_fetch_req,  ef);
      check("fetch_row",  a_fetch_row,  ef ? er : 0);
      check("fetch_col",  a_fetch_col,  ef ? ec : 0);
      check("win_valid",  a_win_valid,  (m_mode == M_COMP) && (m_left == GL_A));
      check("tile_valid", a_tile_valid, et);
      check("tile_row",   a_tile_row,   et ? er : 0);
      check("tile_col",   a_tile_col,   et ? ec : 0);
      check("busy",       a_busy,       m_mode != M_IDLE);
      check("done",       a_done,       m_mode == M_DONE);
    end
  end

  int first, last, lr, lc, ntv, dc, nf, wvc, nwv, nd, f44c, nf44, tvf;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs_a", {a_fetch_req, a_fetch_row, a_fetch_col, a_win_valid, a_tile_valid,
                              a_tile_row, a_tile_col, a_busy, a_done}, 0);
    chk_en  = 1'b1;
    a_reset = 1'b1;

    // Full frame with immediate ack/ready; a start during DONE must be ignored.
    @(negedge clk); a_start = 1; a_ack = 1; a_ready = 1;
    first = -1; last = -1; lr = -1; lc = -1; ntv = 0; dc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) a_start = 0;
      if (a_tile_valid) begin
        if (first < 0) first = c;
        last = c; lr = a_tile_row; lc = a_tile_col; ntv++;
      end
      if (a_done) dc = c;
      if (c == 194) check("busy_after_done", a_busy, 0);
      if (c == 193) a_start = 1;
      if (c == 194) a_start = 0;
    end
    check("first_emit_cycle", first, 3);
    check("last_emit_cycle", last, 192);
    check("last_tile_row", lr, 28);
    check("last_tile_col", lc, 28);
    check("tile_count", ntv, 64);
    check("done_cycle", dc, 193);

    // fetch_ack held off for 5 cycles on tile (0,4).
    @(negedge clk); a_start = 1; a_ack = 1; a_ready = 1;
    nf = 0; wvc = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) a_start = 0;
      if (a_fetch_req && a_fetch_row == 0 && a_fetch_col == 4) nf++;
      if (a_win_valid && c > 4 && wvc < 0) wvc = c;
      if (c == 3) a_ack = 0;
      if (c == 9) a_ack = 1;
    end
    check("delayed_fetch_cycles", nf, 6);
    check("win_valid_after_ack", wvc, 10);
    a_abort = 1; @(negedge clk); a_abort = 0;
    check("busy_after_abort", a_busy, 0);

    // Abort with tile_ready in EMIT of (8,12); a start mid-frame must be ignored.
    @(negedge clk); a_start = 1; a_ack = 1; a_ready = 1;
    nd = 0;
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      if (c == 1 || c == 31) a_start = 0;
      if (c == 30) a_start = 1;
      if (c == 60) begin
        check("emit_8_12_valid", a_tile_valid, 1);
        check("emit_8_12_row", a_tile_row, 8);
        check("emit_8_12_col", a_tile_col, 12);
        a_abort = 1;
      end
      if (c == 61) begin
        check("abort_outputs", {a_fetch_req, a_fetch_row, a_fetch_col, a_win_valid, a_tile_valid,
                                a_tile_row, a_tile_col, a_busy, a_done}, 0);
        a_abort = 0;
      end
      if (c >= 61 && c <= 63 && a_done) nd++;
      if (c == 63) a_start = 1;
      if (c == 64) begin
        a_start = 0;
        check("restart_fetch", {a_fetch_req, a_fetch_row, a_fetch_col}, {1'b1, 12'd0});
      end
    end
    check("no_done_after_abort", nd, 0);
    a_abort = 1; @(negedge clk); a_abort = 0;

    // One-cycle reset during COMPUTE, then start together with abort in IDLE.
    @(negedge clk); a_start = 1; a_ack = 1; a_ready = 1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) a_start = 0;
      if (c == 2) begin check("compute_win_valid", a_win_valid, 1); a_reset = 0; end
      if (c == 3) begin
        check("reset_mid_frame", {a_fetch_req, a_fetch_row, a_fetch_col, a_win_valid, a_tile_valid,
                                  a_tile_row, a_tile_col, a_busy, a_done}, 0);
        a_reset = 1;
      end
      if (c == 4) begin a_start = 1; a_abort = 1; end
      if (c == 5) begin
        a_start = 0; a_abort = 0;
        check("start_beats_abort", {a_fetch_req, a_fetch_row, a_fetch_col, a_busy}, {1'b1, 12'd0, 1'b1});
      end
      if (c == 6) a_abort = 1;
      if (c == 7) a_abort = 0;
    end

    // GRAD_LAT=3 instance: tile_ready low for 4 cycles on tile (4,0).
    @(negedge clk); b_reset = 1;
    @(negedge clk); b_start = 1; b_ack = 1; b_ready = 1;
    nwv = 0; wvc = -1; tvf = -1; ntv = 0; nf44 = 0; f44c = -1;
    for (int c = 1; c <= 56; c++) begin
      @(negedge clk);
      if (c == 1) b_start = 0;
      if (b_win_valid && c >= 41 && c <= 49) begin nwv++; wvc = c; end
      if (b_tile_valid && c >= 41 && tvf < 0) tvf = c;
      if (b_tile_valid && b_tile_row == 4 && b_tile_col == 0) ntv++;
      if (b_fetch_req && b_fetch_row == 4 && b_fetch_col == 4) begin
        nf44++;
        if (f44c < 0) f44c = c;
      end
      if (c == 45) b_ready = 0;
      if (c == 49) b_ready = 1;
    end
    check("b_win_valid_pulses", nwv, 1);
    check("b_win_valid_cycle", wvc, 42);
    check("b_tile_valid_rise", tvf, 45);
    check("b_tile_4_0_held", ntv, 5);
    check("b_advance_count", nf44, 1);
    check("b_advance_cycle", f44c, 50);
    b_abort = 1; @(negedge clk); b_abort = 0;
    check("b_busy_after_abort", b_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
